line_streamer: RTL and testbench
================================

# line_streamer

Parametrised text-line reader that turns a line number into a byte stream of characters. On a request it looks up the line's word-address range in the external line mapper, fetches each packed character word from the external character memory, and unpacks it MSB-byte-first onto a valid/ready byte stream with a last flag. Optional fixed-width mode pads short lines with a fill character and truncates long ones. It sits between the line mapper / character memory and any downstream character consumer.

## Interface
- LINE_W, 8, width of line index
- ADDR_W, 10, character-memory word address width
- WORD_BYTES, 2, characters packed per memory word (≥1)
- PAD_BYTES, 0, fixed output length per line; 0 = natural length
- PAD_CHAR, 8'h20, fill byte for padding and empty lines

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  line request valid
- req_ready  out  1  block can accept a request
- req_line  in  LINE_W  requested line number
- map_line  out  LINE_W  line index to line mapper
- map_addr  in  2*ADDR_W  mapper response {end[ADDR_W-1:0], start[ADDR_W-1:0]}, end inclusive
- mem_addr  out  ADDR_W  character-memory word address
- mem_dout  in  8*WORD_BYTES  character word; byte WORD_BYTES-1 (MSB) is first character
- out_valid  out  1  out_byte valid
- out_ready  in  1  consumer accepts byte
- out_byte  out  8  character
- out_last  out  1  final byte of line
- busy  out  1  state != IDLE

## Operation
- Mapper and memory are registered-read: response reflects the address presented on the previous edge. Block holds map_line/mem_addr stable while waiting.
- FSM: IDLE -> MAP_WAIT -> MAP_CAPT -> MEM_WAIT -> MEM_CAPT -> EMIT -> (MEM_WAIT | PAD | IDLE); PAD -> IDLE.
- IDLE: req_ready=1; on req_valid&req_ready register map_line<=req_line.
- MAP_CAPT: latch start/end; mem_addr<=start; byte count<=0. If end<start (empty line) go to PAD.
- MEM_CAPT: latch mem_dout into shift register, byte index 0.
- EMIT: present current byte; on out_valid&out_ready advance byte index and byte count. After last byte of a word: if word==end, go PAD (if PAD_BYTES>0 and count<PAD_BYTES) else IDLE; otherwise mem_addr<=mem_addr+1 (mod 2^ADDR_W) and go MEM_WAIT.
- PAD: emit PAD_CHAR until count==PAD_BYTES. No memory access.
- Truncation: when PAD_BYTES>0 and count reaches PAD_BYTES, that byte carries out_last; return to IDLE regardless of remaining words.
- Empty line with PAD_BYTES=0: emit exactly one PAD_CHAR with out_last=1. Every request yields ≥1 byte with exactly one out_last.
- Byte count width: clog2(max(PAD_BYTES,1)+1) minimum; natural-length lines do not depend on it.

## Timing
- Reset (rst low): state IDLE, map_line=0, mem_addr=0, out_valid=0, out_last=0, out_byte=0, busy=0; req_ready=1 after rst deasserts. Requests while rst low ignored.
- Reset mid-line: line abandoned immediately, no further bytes; next request after release starts clean.
- Latency: request accepted on edge E0; first out_valid high after edge E0+4.
- Per word: WORD_BYTES handshake cycles + 2 fetch cycles; out_valid low during fetch.
- out_valid, out_byte, out_last stable while out_valid&!out_ready.
- No new request accepted until IDLE; req_ready=0 whenever busy.

## Test plan
- Line 0 map {end=0,start=0}, mem[0]=16'h3131, out_ready=1 -> bytes 0x31,0x31; last on second; first valid 4 cycles after accept; busy low afterward.
- Map {end=3,start=0}, mem 3131/4142/7320/2020 -> 31 31 41 42 73 20 20 20, last only on 8th, 2-cycle valid gap between words.
- Same line with out_ready toggled 1/0 pseudo-randomly -> identical byte sequence, outputs stable during stalls, no loss or duplication.
- PAD_BYTES=5, map {end=0,start=0}, mem[0]=3131 -> 31 31 20 20 20, last on 5th; PAD_BYTES=3 with 2-word line 3131/4142 -> 31 31 41, last on 3rd, mem_addr never reaches 1's successor.
- Empty line map {end=2,start=5}, PAD_BYTES=0 -> single 0x20 with out_last=1; no mem_addr change.
- Assert rst low while mid-word in EMIT -> out_valid=0, busy=0 immediately (asynchronous); after release, new request for line 0 streams 31 31 correctly.

Source files
------------

// File: rtl/line_streamer.sv
// line_streamer: line number -> byte stream.
// Maps a line, fetches packed words, unpacks MSB-first.
module line_streamer #(
  parameter int          LINE_W     = 8,
  parameter int          ADDR_W     = 10,
  parameter int          WORD_BYTES = 2,
  parameter int          PAD_BYTES  = 0,
  parameter logic [7:0]  PAD_CHAR   = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [LINE_W-1:0]       req_line,
  output logic [LINE_W-1:0]       map_line,
  input  logic [2*ADDR_W-1:0]     map_addr,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [8*WORD_BYTES-1:0] mem_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_byte,
  output logic                    out_last,
  output logic                    busy
);

  localparam int DW    = 8 * WORD_BYTES;
  localparam int PB1   = (PAD_BYTES > 0) ? PAD_BYTES : 1;
  localparam int CNT_W = $clog2(PB1 + 1);
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam bit PAD_EN = (PAD_BYTES > 0);
  localparam logic [CNT_W:0] PAD_N = (CNT_W + 1)'(PAD_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MAP_WAIT, S_MAP_CAPT, S_MEM_WAIT,
    S_MEM_CAPT, S_EMIT, S_PAD
  } state_t;

  state_t             state_q, state_d;
  logic [LINE_W-1:0]  map_line_q, map_line_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]  end_q, end_d;
  logic [DW-1:0]      shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0]  m_start, m_end;
  logic [CNT_W:0]     cnt_inc;
  logic               hs, word_last, line_end, trunc, pad_more;

  assign m_start   = map_addr[ADDR_W-1:0];
  assign m_end     = map_addr[2*ADDR_W-1:ADDR_W];
  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  assign word_last = (idx_q == IDX_LAST);
  assign line_end  = (mem_addr_q == end_q);
  assign trunc     = PAD_EN && (cnt_inc == PAD_N);
  assign pad_more  = PAD_EN && (cnt_inc < PAD_N);
  assign hs        = out_valid && out_ready;

  assign map_line  = map_line_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = (state_q != S_IDLE);
  assign req_ready = (state_q == S_IDLE);

  // State and datapath registers; reset abandons any line in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      map_line_q <= '0;
      mem_addr_q <= '0;
      end_q      <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      map_line_q <= map_line_d;
      mem_addr_q <= mem_addr_d;
      end_q      <= end_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state, fetch sequencing and byte-stream outputs.
  always_comb begin
    state_d    = state_q;
    map_line_d = map_line_q;
    mem_addr_d = mem_addr_q;
    end_d      = end_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    out_valid  = 1'b0;
    out_byte   = 8'h00;
    out_last   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          map_line_d = req_line;
          state_d    = S_MAP_WAIT;
        end
      end
      S_MAP_WAIT: state_d = S_MAP_CAPT;
      S_MAP_CAPT: begin
        end_d = m_end;
        cnt_d = '0;
        if (m_end < m_start) begin
          state_d = S_PAD;
        end else begin
          mem_addr_d = m_start;
          state_d    = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: state_d = S_MEM_CAPT;
      S_MEM_CAPT: begin
        shift_d = mem_dout;
        idx_d   = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_byte  = shift_q[DW-1 -: 8];
        out_last  = trunc || (word_last && line_end && !pad_more);
        if (hs) begin
          cnt_d   = cnt_inc[CNT_W-1:0];
          idx_d   = idx_q + 1'b1;
          shift_d = shift_q << 8;
          if (out_last) begin
            state_d = S_IDLE;
          end else if (word_last) begin
            if (line_end) begin
              state_d = S_PAD;
            end else begin
              mem_addr_d = mem_addr_q + 1'b1;
              state_d    = S_MEM_WAIT;
            end
          end
        end
      end
      S_PAD: begin
        out_valid = 1'b1;
        out_byte  = PAD_CHAR;
        out_last  = !PAD_EN || (cnt_inc == PAD_N);
        if (hs) begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (out_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_streamer.sv
// tb_line_streamer: natural-length and padded instances
// checked against a queue-based line model.
module tb_line_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [7:0]  req_line  [2];
  logic [7:0]  map_line  [2];
  logic [19:0] map_addr  [2];
  logic [9:0]  mem_addr  [2];
  logic [15:0] mem_dout  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [7:0]  out_byte  [2];
  logic        out_last  [2];
  logic        busy      [2];

  logic [19:0] map_mem  [256];
  logic [15:0] char_mem [1024];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  logic       lst_q [$];

  always #5 clk = ~clk;

  line_streamer #(.PAD_BYTES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_line(req_line[0]), .map_line(map_line[0]),
    .map_addr(map_addr[0]), .mem_addr(mem_addr[0]),
    .mem_dout(mem_dout[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_byte(out_byte[0]),
    .out_last(out_last[0]), .busy(busy[0])
  );

  line_streamer #(.PAD_BYTES(5)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_line(req_line[1]), .map_line(map_line[1]),
    .map_addr(map_addr[1]), .mem_addr(mem_addr[1]),
    .mem_dout(mem_dout[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_byte(out_byte[1]),
    .out_last(out_last[1]), .busy(busy[1])
  );

  // Registered-read mapper and character memory per instance.
  always @(posedge clk) begin
    map_addr[0] <= map_mem[map_line[0]];
    map_addr[1] <= map_mem[map_line[1]];
    mem_dout[0] <= char_mem[mem_addr[0]];
    mem_dout[1] <= char_mem[mem_addr[1]];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected stream: concatenate words, then pad/truncate.
  task automatic build_exp(input int pad, input int line);
    int s, e;
    logic [15:0] w;
    s = int'(map_mem[line][9:0]);
    e = int'(map_mem[line][19:10]);
    exp_q.delete();
    if (e < s) begin
      if (pad == 0) exp_q.push_back(8'h20);
      else repeat (pad) exp_q.push_back(8'h20);
    end else begin
      for (int a = s; a <= e; a++) begin
        w = char_mem[a];
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
      end
      if (pad > 0) begin
        while (exp_q.size() > pad) void'(exp_q.pop_back());
        while (exp_q.size() < pad) exp_q.push_back(8'h20);
      end
    end
  endtask

  task automatic run_line(input int d, input int line, input int rmode,
                          input int lat_e, input int gap_e,
                          input int maxa_e);
    int n, first, gaps, maxa;
    bit done, stalled;
    logic [8:0] saved;
    build_exp(d == 1 ? 5 : 0, line);
    got_q.delete();
    lst_q.delete();
    @(negedge clk);
    chk("req_ready", 32'(req_ready[d]), 32'd1);
    req_line[d] = 8'(line);
    req_valid[d] = 1'b1;
    out_ready[d] = 1'b0;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    n = 0; first = -1; gaps = 0; done = 0; stalled = 0;
    saved = '0;
    maxa = int'(mem_addr[d]);
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (int'(mem_addr[d]) > maxa) maxa = int'(mem_addr[d]);
      if (stalled) begin
        chk("stall_valid", 32'(out_valid[d]), 32'd1);
        chk("stall_data", 32'({out_last[d], out_byte[d]}), 32'(saved));
      end
      out_ready[d] = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid[d]) begin
        if (first < 0) first = n;
        if (out_ready[d]) begin
          got_q.push_back(out_byte[d]);
          lst_q.push_back(out_last[d]);
          stalled = 0;
          if (out_last[d]) done = 1;
        end else begin
          stalled = 1;
          saved = {out_last[d], out_byte[d]};
        end
      end else if (first >= 0) begin
        gaps++;
      end
    end
    chk("line_done", 32'(done), 32'd1);
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk("busy_after", 32'(busy[d]), 32'd0);
    chk("valid_after", 32'(out_valid[d]), 32'd0);
    chk("length", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("byte%0d_line%0d_dut%0d", i, line, d),
          32'({lst_q[i], got_q[i]}),
          32'({i == exp_q.size() - 1, exp_q[i]}));
    if (lat_e >= 0) chk("first_valid", 32'(first), 32'(lat_e));
    if (gap_e >= 0) chk("gap_cycles", 32'(gaps), 32'(gap_e));
    if (maxa_e >= 0) chk("max_mem_addr", 32'(maxa), 32'(maxa_e));
  endtask

  typedef struct {
    int d;
    int line;
    int rmode;
    int lat;
    int gap;
    int maxa;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int w, s, len;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_line[k]  = 8'h00;
      out_ready[k] = 1'b0;
    end
    for (int a = 0; a < 1024; a++) char_mem[a] = 16'($urandom);
    for (int l = 0; l < 256; l++) map_mem[l] = 20'h0;
    char_mem[0] = 16'h3131;
    char_mem[1] = 16'h4142;
    char_mem[2] = 16'h7320;
    char_mem[3] = 16'h2020;
    map_mem[0] = {10'd0, 10'd0};
    map_mem[1] = {10'd3, 10'd0};
    map_mem[2] = {10'd2, 10'd5};
    for (int l = 10; l < 30; l++) begin
      s = $urandom_range(100, 1000);
      len = $urandom_range(0, 5);
      map_mem[l] = {10'(s + len - 1), 10'(s)};
    end
    map_mem[30] = {10'd1023, 10'd1021};

    tbl[0] = '{0, 0, 0, 5, 0, 0};
    tbl[1] = '{0, 1, 0, 5, 6, 3};
    tbl[2] = '{0, 1, 1, 5, -1, 3};
    tbl[3] = '{0, 2, 0, -1, 0, 3};
    tbl[4] = '{1, 0, 0, 5, 0, 0};
    tbl[5] = '{1, 1, 0, 5, 4, 2};
    tbl[6] = '{1, 2, 0, -1, 0, 2};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_map_line", 32'(map_line[k]), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr[k]), 32'd0);
      chk("rst_out", 32'({out_valid[k], out_last[k], out_byte[k]}), 32'd0);
      chk("rst_busy", 32'(busy[k]), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("req_ready_post_rst", 32'(req_ready[0]), 32'd1);

    for (int i = 0; i < 7; i++)
      run_line(tbl[i].d, tbl[i].line, tbl[i].rmode,
               tbl[i].lat, tbl[i].gap, tbl[i].maxa);

    for (int i = 0; i < 40; i++)
      run_line(i % 2, $urandom_range(10, 30), $urandom_range(0, 1),
               -1, -1, -1);

    // Reset while a word is being emitted under backpressure.
    @(negedge clk);
    req_line[0] = 8'd1;
    req_valid[0] = 1'b1;
    out_ready[0] = 1'b0;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    w = 0;
    while (!out_valid[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("pre_rst_valid", 32'(out_valid[0]), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_out", 32'({out_last[0], out_byte[0]}), 32'd0);
    req_line[0] = 8'd7;
    req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    req_valid[0] = 1'b0;
    chk("rst_ignore_line", 32'(map_line[0]), 32'd0);
    chk("rst_ignore_busy", 32'(busy[0]), 32'd0);
    rst = 1'b1;
    run_line(0, 0, 0, 5, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
